dec_scan_nto2n: RTL and testbench
=================================

// Module: dec_scan_nto2n
// PURPOSE
//  Parametrised N-to-2^N one-hot decoder, the generalised successor of the 3-to-8 decoder.
//  Registered outputs with enable, selectable output polarity, and an autonomous scan mode.
//  In scan mode the active output walks 0..2^N-1 with a programmable dwell time, for
//  row/digit-strobe and select-line sequencing. Sits between control logic and strobed loads.
// PARAMETERS
//  N          3   select width; output width is 2^N
//  DWELL_W    8   width of DWELL input / dwell counter
//  ACTIVE_LOW 0   1: active output driven 0, inactive outputs 1
// PORTS
//  CLK     in   1        clock; all state changes on rising edge
//  RST     in   1        asynchronous, active-high reset
//  EN      in   1        1: decoder active; 0: all outputs inactive, state frozen
//  MODE    in   1        0: direct decode of SEL; 1: scan
//  SEL     in   N        select code (direct mode)
//  DWELL   in   DWELL_W  scan: each index is held DWELL+1 enabled cycles
//  Y       out  2^N      registered one-hot (polarity per ACTIVE_LOW)
//  IDX     out  N        registered index currently shown on Y
//  STEP_P  out  1        1-cycle pulse: first cycle a new scan index appears on Y
//  WRAP_P  out  1        1-cycle pulse with STEP_P when the new index is 0
// BEHAVIOUR
//  Reset (async, immediate): Y all inactive, IDX=0, dwell cnt=0, STEP_P=WRAP_P=0.
//  Invariant: Y is one-hot or all-inactive; never more than one active bit.
//  Direct (MODE=0, EN=1): 1-cycle latency; after edge, IDX=SEL, Y[SEL] active.
//    No STEP_P/WRAP_P. Dwell cnt held at 0.
//  Scan (MODE=1, EN=1): Y[IDX] active. cnt increments each cycle. When cnt>=DWELL:
//    cnt<=0, IDX<=IDX+1 mod 2^N, STEP_P=1 that next cycle, WRAP_P=1 if new IDX==0.
//    Comparison is >= against live DWELL: lowering DWELL below cnt advances on next edge.
//    DWELL=0: IDX advances every cycle, STEP_P continuously high.
//  Mode entry 0->1: scan starts at current IDX (last SEL), cnt=0; no STEP_P on entry.
//  Mode exit 1->0: next edge loads SEL as in direct mode; cnt cleared.
//  EN=0 (either mode): next edge Y all inactive, pulses 0; IDX and cnt frozen.
//    Re-enable resumes scan from frozen IDX/cnt (remaining dwell DWELL-cnt+1 cycles).
//  Simultaneous EN rise and MODE change: MODE rules apply, as if EN had been high.
// STRUCTURE
//  Header dec_defs.vh: MODE_DIRECT=1'b0, MODE_SCAN=1'b1 localparams, polarity helper macro.
//  Sub-module dwell_timer (DWELL_W): cnt, clr, hold, tick output on cnt>=DWELL.
//  Top: index register, one-hot decode of IDX, polarity XOR, pulse registers.
// TESTING
//  1 N=3, direct, EN=1, SEL 7,6..0 one per 10ns -> Y 10000000,01000000..00000001 one cycle later.
//  2 EN=0 -> Y=00000000; ACTIVE_LOW=1 instance, SEL=5, EN=1 -> Y=11011111, EN=0 -> 11111111.
//  3 Scan, DWELL=2, from IDX=0 -> each one-hot held 3 cycles, STEP_P every 3rd cycle,
//    WRAP_P on 7->0 transition 24 cycles after entry; no STEP_P on entry cycle.
//  4 DWELL=0 -> IDX 0,1..7,0 each cycle; STEP_P stays 1; WRAP_P every 8th cycle.
//  5 Scan DWELL=2, IDX=4, cnt=1, EN=0 for 5 cycles -> Y inactive, IDX=4;
//    re-enable -> Y[4] 2 cycles, then IDX=5 with STEP_P.
//  6 DWELL 5->1 at cnt=3 -> advance next edge; RST pulsed mid-cycle -> Y inactive
//    before next edge, IDX=0; repeat 1 and 4 with N=4 (16 outputs).

Source files
------------

// File: rtl/dec_scan_nto2n_pkg.sv
// Shared definitions for the dec_scan_nto2n decoder.
//   mode_t / MODE_DIRECT / MODE_SCAN : encoding of the MODE input
//   op_e / decode_op()               : per-edge operation chosen from EN and MODE
package dec_scan_nto2n_pkg;

   typedef logic mode_t;

   localparam mode_t MODE_DIRECT = 1'b0;
   localparam mode_t MODE_SCAN   = 1'b1;

   // What the decoder does on the next clock edge.
   typedef enum logic [1:0] {
      OpHold,  // disabled: outputs inactive, index and dwell count frozen
      OpLoad,  // direct decode of the select code
      OpScan   // autonomous walk through the outputs
   } op_e;

   // EN low dominates; otherwise MODE picks the operation. An EN rise that
   // coincides with a MODE change therefore follows the new MODE directly.
   function automatic op_e decode_op(logic en, mode_t mode);
      if (!en) begin
         return OpHold;
      end else if (mode == MODE_SCAN) begin
         return OpScan;
      end
      return OpLoad;
   endfunction

endpackage

// File: rtl/dec_scan_nto2n_dwell_timer.sv
// Dwell counter for the scan sequencer.
//   clk   : clock
//   rst   : asynchronous, active-high reset (count to 0)
//   clr   : synchronous clear of the count
//   hold  : freeze the count
//   dwell : live dwell limit
//   cnt   : current count
//   tick  : count has reached the limit; the counter wraps to 0 on this edge
module dec_scan_nto2n_dwell_timer #(
   parameter int unsigned DWELL_W = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               clr,
   input  logic               hold,
   input  logic [DWELL_W-1:0] dwell,
   output logic [DWELL_W-1:0] cnt,
   output logic               tick
);

   logic [DWELL_W-1:0] cnt_q;
   logic [DWELL_W-1:0] cnt_d;

   // >= rather than == so that lowering the limit below the count still ends
   // the dwell on the very next edge.
   assign tick = (cnt_q >= dwell);
   assign cnt  = cnt_q;

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (!hold) begin
         cnt_d = tick ? '0 : cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/dec_scan_nto2n.sv
// N-to-2^N one-hot decoder with registered outputs, enable, selectable output
// polarity and an autonomous scan mode that walks the active output through
// all 2^N positions with a programmable dwell time.
//   clk    : clock, all state changes on the rising edge
//   rst    : asynchronous, active-high reset
//   en     : 1 = decoder active; 0 = outputs inactive, index/dwell frozen
//   mode   : MODE_DIRECT decodes sel; MODE_SCAN walks the outputs
//   sel    : select code for direct mode
//   dwell  : in scan mode each index is held dwell+1 enabled cycles
//   y      : registered one-hot output (active level set by ACTIVE_LOW)
//   idx    : registered index currently shown on y
//   step_p : one-cycle pulse, first cycle a new scan index is shown
//   wrap_p : one-cycle pulse together with step_p when the new index is 0
module dec_scan_nto2n
   import dec_scan_nto2n_pkg::*;
#(
   parameter int unsigned N          = 3,
   parameter int unsigned DWELL_W    = 8,
   parameter bit          ACTIVE_LOW = 1'b0
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                en,
   input  logic                mode,
   input  logic [N-1:0]        sel,
   input  logic [DWELL_W-1:0]  dwell,
   output logic [(1<<N)-1:0]   y,
   output logic [N-1:0]        idx,
   output logic                step_p,
   output logic                wrap_p
);

   localparam int unsigned W = 1 << N;

   // XOR mask that turns the internal active-high pattern into the output level.
   localparam logic [W-1:0] POL_MASK = {W{ACTIVE_LOW}};

   op_e              op;
   logic             tick;
   logic [DWELL_W-1:0] cnt;

   logic [N-1:0] idx_q, idx_d;
   logic [W-1:0] y_q, y_d;
   logic         step_q, step_d;
   logic         wrap_q, wrap_d;
   logic         active;
   logic [W-1:0] one_hot;

   assign op = decode_op(en, mode);

   dec_scan_nto2n_dwell_timer #(
      .DWELL_W (DWELL_W)
   ) u_dwell_timer (
      .clk   (clk),
      .rst   (rst),
      .clr   (op == OpLoad),
      .hold  (op == OpHold),
      .dwell (dwell),
      .cnt   (cnt),
      .tick  (tick)
   );

   always_comb begin
      idx_d   = idx_q;
      step_d  = 1'b0;
      wrap_d  = 1'b0;
      active  = 1'b0;
      one_hot = '0;
      unique case (op)
         OpLoad: begin
            idx_d  = sel;
            active = 1'b1;
         end
         OpScan: begin
            active = 1'b1;
            if (tick) begin
               // Natural N-bit overflow gives the modulo-2^N wrap.
               idx_d  = idx_q + 1'b1;
               step_d = 1'b1;
               wrap_d = (idx_d == '0);
            end
         end
         default: ;
      endcase
      // Only one bit is ever set, so y stays one-hot or all-inactive.
      if (active) begin
         one_hot[idx_d] = 1'b1;
      end
      y_d = one_hot ^ POL_MASK;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idx_q  <= '0;
         y_q    <= POL_MASK;
         step_q <= 1'b0;
         wrap_q <= 1'b0;
      end else begin
         idx_q  <= idx_d;
         y_q    <= y_d;
         step_q <= step_d;
         wrap_q <= wrap_d;
      end
   end

   assign y      = y_q;
   assign idx    = idx_q;
   assign step_p = step_q;
   assign wrap_p = wrap_q;

endmodule

// File: tb/tb_dec_scan_nto2n.sv
// Self-checking bench for dec_scan_nto2n. Three instances share the stimulus:
//   u_dut0 : N=3, active-high
//   u_dut1 : N=3, active-low
//   u_dut2 : N=4, active-high
// A behavioural model tracks, per instance, the shown index, how long it has
// been shown, and whether the outputs are live.
module tb_dec_scan_nto2n;

   logic        clk = 1'b0;
   logic        rst;
   logic        en;
   logic        mode;
   logic [3:0]  sel;
   logic [7:0]  dwell;

   logic [7:0]  y0, y1;
   logic [15:0] y2;
   logic [2:0]  idx0, idx1;
   logic [3:0]  idx2;
   logic        step0, step1, step2;
   logic        wrap0, wrap1, wrap2;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   dec_scan_nto2n #(.N(3), .DWELL_W(8), .ACTIVE_LOW(1'b0)) u_dut0 (
      .clk (clk), .rst (rst), .en (en), .mode (mode), .sel (sel[2:0]), .dwell (dwell),
      .y (y0), .idx (idx0), .step_p (step0), .wrap_p (wrap0)
   );

   dec_scan_nto2n #(.N(3), .DWELL_W(8), .ACTIVE_LOW(1'b1)) u_dut1 (
      .clk (clk), .rst (rst), .en (en), .mode (mode), .sel (sel[2:0]), .dwell (dwell),
      .y (y1), .idx (idx1), .step_p (step1), .wrap_p (wrap1)
   );

   dec_scan_nto2n #(.N(4), .DWELL_W(8), .ACTIVE_LOW(1'b0)) u_dut2 (
      .clk (clk), .rst (rst), .en (en), .mode (mode), .sel (sel), .dwell (dwell),
      .y (y2), .idx (idx2), .step_p (step2), .wrap_p (wrap2)
   );

   // ---------------- reference model ----------------
   int sizes [3] = '{8, 8, 16};
   bit alow  [3] = '{1'b0, 1'b1, 1'b0};
   int m_idx [3];
   int m_age [3];  // enabled scan cycles already spent on the current index
   bit m_on  [3];
   bit m_step[3];
   bit m_wrap[3];

   task automatic model_reset();
      for (int k = 0; k < 3; k++) begin
         m_idx[k] = 0; m_age[k] = 0; m_on[k] = 0; m_step[k] = 0; m_wrap[k] = 0;
      end
   endtask

   // Apply one clock edge with the inputs that were present before it.
   task automatic model_edge();
      for (int k = 0; k < 3; k++) begin
         m_step[k] = 0;
         m_wrap[k] = 0;
         if (!en) begin
            m_on[k] = 0;
         end else if (!mode) begin
            m_on[k]  = 1;
            m_idx[k] = int'(sel) % sizes[k];
            m_age[k] = 0;
         end else begin
            m_on[k] = 1;
            if (m_age[k] >= int'(dwell)) begin
               m_idx[k]  = (m_idx[k] + 1) % sizes[k];
               m_age[k]  = 0;
               m_step[k] = 1;
               m_wrap[k] = (m_idx[k] == 0);
            end else begin
               m_age[k] = m_age[k] + 1;
            end
         end
      end
   endtask

   function automatic logic [31:0] exp_y(int k);
      int v;
      v = m_on[k] ? (1 << m_idx[k]) : 0;
      if (alow[k]) v = v ^ ((1 << sizes[k]) - 1);
      return v;
   endfunction

   function automatic logic [31:0] act_y(int k);
      case (k)
         0: return {24'b0, y0};
         1: return {24'b0, y1};
         default: return {16'b0, y2};
      endcase
   endfunction

   function automatic logic [31:0] act_idx(int k);
      case (k)
         0: return {29'b0, idx0};
         1: return {29'b0, idx1};
         default: return {28'b0, idx2};
      endcase
   endfunction

   function automatic logic [31:0] act_step(int k);
      case (k)
         0: return {31'b0, step0};
         1: return {31'b0, step1};
         default: return {31'b0, step2};
      endcase
   endfunction

   function automatic logic [31:0] act_wrap(int k);
      case (k)
         0: return {31'b0, wrap0};
         1: return {31'b0, wrap1};
         default: return {31'b0, wrap2};
      endcase
   endfunction

   // ---------------- checking ----------------
   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s at %0t: got=%0h expected=%0h", tag, $time, act, exp);
      end
   endtask

   task automatic check_all(input string phase);
      for (int k = 0; k < 3; k++) begin
         check_eq($sformatf("%s.y%0d", phase, k), act_y(k), exp_y(k));
         check_eq($sformatf("%s.idx%0d", phase, k), act_idx(k), m_idx[k]);
         check_eq($sformatf("%s.step%0d", phase, k), act_step(k), {31'b0, m_step[k]});
         check_eq($sformatf("%s.wrap%0d", phase, k), act_wrap(k), {31'b0, m_wrap[k]});
      end
   endtask

   task automatic cycle(input string phase);
      @(posedge clk);
      model_edge();
      #1;
      check_all(phase);
   endtask

   // Reset asserted and released between two edges; outputs must clear at once.
   task automatic mid_cycle_reset(input string phase);
      #2 rst = 1'b1;
      #1;
      model_reset();
      check_all(phase);
      #1 rst = 1'b0;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      rst = 1'b1; en = 1'b0; mode = 1'b0; sel = '0; dwell = '0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_all("reset");
      check_eq("reset.y0_const", {24'b0, y0}, 32'h00);
      check_eq("reset.y1_const", {24'b0, y1}, 32'hFF);
      rst = 1'b0;

      // Direct decode, select walking down.
      en = 1'b1;
      for (int s = 7; s >= 0; s--) begin
         sel = 4'(s);
         cycle("direct");
      end
      check_eq("direct.y0_last", {24'b0, y0}, 32'h01);

      // Disable, then active-low view of sel=5.
      en = 1'b0;
      cycle("disable");
      sel = 4'd5; en = 1'b1;
      cycle("sel5");
      check_eq("sel5.y1_const", {24'b0, y1}, 32'hDF);
      en = 1'b0;
      cycle("disable2");
      check_eq("disable2.y1_const", {24'b0, y1}, 32'hFF);

      // Scan with dwell 2 from index 0.
      en = 1'b1; mode = 1'b0; sel = 4'd0;
      cycle("preload0");
      dwell = 8'd2; mode = 1'b1;
      repeat (26) cycle("scan_d2");

      // Dwell 0: advance every cycle.
      dwell = 8'd0;
      repeat (34) cycle("scan_d0");

      // Freeze mid-dwell, then resume.
      mode = 1'b0; sel = 4'd4;
      cycle("preload4");
      dwell = 8'd2; mode = 1'b1;
      cycle("scan_cnt1");
      en = 1'b0;
      repeat (5) cycle("frozen");
      en = 1'b1;
      repeat (4) cycle("resume");

      // Lower the dwell limit below the running count.
      mode = 1'b0; sel = 4'd2;
      cycle("preload2");
      dwell = 8'd5; mode = 1'b1;
      repeat (3) cycle("scan_d5");
      dwell = 8'd1;
      repeat (3) cycle("dwell_drop");

      mid_cycle_reset("async_rst");
      repeat (4) cycle("after_rst");

      // Wide instance direct decode over its full range.
      mode = 1'b0;
      for (int s = 15; s >= 0; s--) begin
         sel = 4'(s);
         cycle("direct16");
      end

      // Randomized mix of modes, enables, dwell changes and resets.
      for (int i = 0; i < 600; i++) begin
         en = ($urandom_range(0, 9) != 0);
         if ($urandom_range(0, 9) == 0) mode = ~mode;
         sel = 4'($urandom);
         if ($urandom_range(0, 19) == 0) dwell = 8'($urandom_range(0, 4));
         cycle("random");
         if ($urandom_range(0, 99) == 0) mid_cycle_reset("random_rst");
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
